// File: rtl/seg7_decoder_monitor.sv
// Receive-side 7-segment monitor: synchronises, debounces and decodes an active-low
// 2-bit digit pattern, classifies each committed change and tallies errors.
module seg7_decoder_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [6:0]       segments,
  output logic [1:0]       count,
  output logic             count_valid,
  output logic             new_pulse,
  output logic             up_pulse,
  output logic             down_pulse,
  output logic             skip_pulse,
  output logic             bad_pulse,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic {
    NO_REF = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [7:0]       HOLD_MAX = 8'(STABLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
  localparam logic [6:0]       BLANK    = 7'b111_1111;

  state_t           state, state_next;
  logic [6:0]       sync1, seg_s, cand;
  logic [7:0]       hold;
  logic             armed;
  logic             commit;

  logic             pat_legal, pat_blank;
  logic [1:0]       pat_digit;
  logic [1:0]       diff;

  logic [1:0]       count_next;
  logic             valid_next;
  logic             new_next, up_next, down_next, skip_next, bad_next;
  logic             err_inc;
  logic [ERR_W-1:0] err_next;

  // Two-flop synchroniser for the asynchronous segment lines.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= BLANK;
      seg_s <= BLANK;
    end else begin
      sync1 <= segments;
      seg_s <= sync1;
    end
  end

  // Debounce: a candidate must hold for STABLE_CYCLES samples; armed limits it to one commit.
  assign commit = (seg_s == cand) && (hold >= HOLD_MAX) && armed;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cand  <= BLANK;
      hold  <= 8'd0;
      armed <= 1'b0;
    end else if (seg_s != cand) begin
      cand  <= seg_s;
      hold  <= 8'd0;
      armed <= 1'b1;
    end else if (hold < HOLD_MAX) begin
      hold <= hold + 8'd1;
    end else if (armed) begin
      armed <= 1'b0;
    end
  end

  always_comb begin
    pat_legal = 1'b1;
    pat_blank = 1'b0;
    pat_digit = 2'd0;
    case (cand)
      7'b000_0001: pat_digit = 2'd0;
      7'b100_1111: pat_digit = 2'd1;
      7'b001_0010: pat_digit = 2'd2;
      7'b000_0110: pat_digit = 2'd3;
      7'b111_1111: pat_blank = 1'b1;
      default:     pat_legal = 1'b0;
    endcase
  end

  // Mod-4 distance from the held digit decides up / down / skip.
  assign diff = pat_digit - count;

  always_comb begin
    state_next = state;
    count_next = count;
    valid_next = count_valid;
    new_next   = 1'b0;
    up_next    = 1'b0;
    down_next  = 1'b0;
    skip_next  = 1'b0;
    bad_next   = 1'b0;
    err_inc    = 1'b0;
    if (commit) begin
      if (pat_blank) begin
        valid_next = 1'b0;
        state_next = NO_REF;
      end else if (!pat_legal) begin
        bad_next   = 1'b1;
        err_inc    = 1'b1;
        valid_next = 1'b0;
        state_next = NO_REF;
      end else if (state == NO_REF) begin
        count_next = pat_digit;
        valid_next = 1'b1;
        new_next   = 1'b1;
        state_next = LOCKED;
      end else if (pat_digit != count) begin
        count_next = pat_digit;
        new_next   = 1'b1;
        case (diff)
          2'd1:    up_next   = 1'b1;
          2'd3:    down_next = 1'b1;
          default: begin
            skip_next = 1'b1;
            err_inc   = 1'b1;
          end
        endcase
      end
    end
  end

  assign err_next = (err_inc && (err_count != ERR_MAX)) ? err_count + 1'b1 : err_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= NO_REF;
      count       <= 2'd0;
      count_valid <= 1'b0;
      new_pulse   <= 1'b0;
      up_pulse    <= 1'b0;
      down_pulse  <= 1'b0;
      skip_pulse  <= 1'b0;
      bad_pulse   <= 1'b0;
      err_count   <= '0;
    end else begin
      state       <= state_next;
      count       <= count_next;
      count_valid <= valid_next;
      new_pulse   <= new_next;
      up_pulse    <= up_next;
      down_pulse  <= down_next;
      skip_pulse  <= skip_next;
      bad_pulse   <= bad_next;
      err_count   <= err_next;
    end
  end

endmodule

// File: doc/seg7_decoder_monitor.md
Name: seg7_decoder_monitor

Overview:
Receive-side counterpart of the 2-bit seven-segment encoder. The block samples an active-low 7-segment pattern, synchronises and debounces it, and decodes it back to a 2-bit count. It also classifies each accepted change as a step up, a step down or an illegal skip, and keeps a saturating error tally. It sits on the loopback/verification path of the manual counter display, or on any input that carries encoded digits.

Parameters:
STABLE_CYCLES, 4, consecutive synchronised samples a pattern must hold before it is committed (legal range 1..255)
ERR_W, 8, width of the saturating error counter

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
segments  input  7  active-low segment lines; bit6 = a ... bit0 = g; asynchronous to clk
count  output  2  last committed decoded digit
count_valid  output  1  level; high while the last committed pattern was a legal digit
new_pulse  output  1  one-cycle pulse on commit of a digit different from the previous committed digit, or of the first digit after NO_REF
up_pulse  output  1  one-cycle pulse; committed digit = previous + 1 mod 4 (3->0 included)
down_pulse  output  1  one-cycle pulse; committed digit = previous - 1 mod 4 (0->3 included)
skip_pulse  output  1  one-cycle pulse; committed digit = previous +/- 2 mod 4
bad_pulse  output  1  one-cycle pulse; illegal pattern committed
err_count  output  ERR_W  saturating count of skip and bad events

Behaviour:
- Legal patterns: 0000001->0; 1001111->1; 0010010->2; 0000110->3; 1111111 = blank. Every other pattern is illegal.
- Reset (async assert, sync-free release): both sync flops = 7'b111_1111; cand = 7'b111_1111; hold = 0; count = 0; count_valid = 0; all pulses = 0; err_count = 0; state = NO_REF.
- Synchroniser: two flops; seg_s = second flop output.
- Debounce, on each edge:
  - seg_s != cand: cand <= seg_s, hold <= 0, armed <= 1.
  - else if hold < STABLE_CYCLES-1: hold++.
  - else if armed: commit cand, armed <= 0.
- Each cand value commits at most once. Latency from an input change to output update is STABLE_CYCLES+3 edges; with STABLE_CYCLES=4, outputs change on the 7th edge. Glitches shorter than the debounce window never commit.
- FSM states: NO_REF and LOCKED. On commit:
  - Legal digit in NO_REF: count <= digit, count_valid <= 1, new_pulse, go to LOCKED. No direction pulse.
  - Legal digit in LOCKED, same as count: no pulses, no change. This covers a glitch away and back.
  - Legal digit in LOCKED, different from count: count updated, new_pulse plus exactly one of up_pulse, down_pulse or skip_pulse. On skip, err_count++.
  - Blank: count_valid <= 0, count held, go to NO_REF, no pulses.
  - Illegal pattern: bad_pulse, err_count++, count_valid <= 0, count held, go to NO_REF.
- err_count saturates at 2^ERR_W-1 and never wraps.
- Pulses are registered and high for exactly one cycle. At most one commit per cycle, so up_pulse, down_pulse, skip_pulse and bad_pulse are mutually exclusive.
- Reset asserted mid-debounce or mid-pulse clears everything immediately. After release, a stable input commits after the full latency and is treated as first-after-NO_REF.

Test Plan:
- Reset, segments held at 7'b000_0001 -> the 7th edge after release gives count=0, count_valid=1, new_pulse for one cycle, no up/down/skip.
- From locked 0, apply 1001111, then 0010010, then 0000110, then 0000001, each held 10 cycles -> four up_pulses (the last is the 3->0 wrap), count sequence 1,2,3,0, err_count=0.
- From locked 2, apply 0000001 -> skip_pulse, count=0, err_count=1. Then apply 1001111 -> up_pulse, err_count stays 1.
- From locked 1, apply a 3-cycle glitch to 0010010, then return to 1001111 -> no pulses, count stays 1. Then apply 1111111 for 10 cycles -> count_valid=0, count=1. Then apply 0010010 -> new_pulse only, no direction pulse.
- Apply illegal 7'b000_0000 for 10 cycles -> bad_pulse, count_valid=0, err_count++. With ERR_W=2, four illegal commits leave err_count at 3 (saturated).
- Drop reset_n mid-debounce (hold=2) -> all outputs are 0 within the same cycle. On release with the input stable, the commit occurs on the 7th edge.
